// File: rtl/pattern_generator_n.sv
// LFSR-driven pattern generator: a frame of NUM_CELLS cells, updated once per
// STEP_DIV enabled clocks either by random-fill (one cell) or by scrolling.
module pattern_generator_n #(
  parameter int          NUM_CELLS = 16,
  parameter int          PATTERN_W = 3,
  parameter int          STEP_DIV  = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                           clk_1,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           clear,
  input  logic                           mode,
  output logic [NUM_CELLS*PATTERN_W-1:0] pattern,
  output logic                           frame_valid,
  output logic [7:0]                     step_count
);

  localparam int          IDX_W      = $clog2(NUM_CELLS);
  localparam int          FW         = NUM_CELLS * PATTERN_W;
  localparam logic [15:0] LP_SEED    = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LP_DIV_MAX = 16'(STEP_DIV - 1);

  logic [15:0]          r_divCnt;
  logic [15:0]          r_lfsr;
  logic [FW-1:0]        r_pattern;
  logic                 r_valid;
  logic [7:0]           r_stepCount;

  logic                 w_step;
  logic [15:0]          w_lfsrNext;
  logic [PATTERN_W-1:0] w_cellData;
  logic [IDX_W-1:0]     w_cellIdx;
  logic [FW-1:0]        w_patternNext;

  assign w_step     = enable && (r_divCnt == LP_DIV_MAX);
  assign w_lfsrNext = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_cellData = w_lfsrNext[PATTERN_W-1:0];
  assign w_cellIdx  = r_stepCount[IDX_W-1:0];

  // Mode is only consulted here, so a mid-period change lands at the next step.
  always_comb begin
    w_patternNext = r_pattern;
    if (mode) begin
      w_patternNext = {r_pattern[FW-PATTERN_W-1:0], w_cellData};
    end else begin
      w_patternNext[int'(w_cellIdx)*PATTERN_W +: PATTERN_W] = w_cellData;
    end
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_divCnt    <= 16'h0000;
      r_lfsr      <= LP_SEED;
      r_pattern   <= '0;
      r_valid     <= 1'b0;
      r_stepCount <= 8'h00;
    end else if (clear) begin
      r_divCnt    <= 16'h0000;
      r_lfsr      <= LP_SEED;
      r_pattern   <= '0;
      r_valid     <= 1'b0;
      r_stepCount <= 8'h00;
    end else begin
      r_valid <= w_step;
      if (enable) begin
        r_divCnt <= w_step ? 16'h0000 : r_divCnt + 16'h0001;
      end
      if (w_step) begin
        r_lfsr      <= w_lfsrNext;
        r_pattern   <= w_patternNext;
        r_stepCount <= r_stepCount + 8'h01;
      end
    end
  end

  assign pattern     = r_pattern;
  assign frame_valid = r_valid;
  assign step_count  = r_stepCount;

endmodule

// File: tb/tb_pattern_generator_n.sv
// Scoreboard bench for pattern_generator_n: a behavioural model pushes the
// expected outputs for each edge, which are popped and compared after it.
module tb_pattern_generator_n;

  localparam int          NUM_CELLS = 16;
  localparam int          PATTERN_W = 3;
  localparam int          STEP_DIV  = 4;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          FW        = NUM_CELLS * PATTERN_W;
  localparam int          IDX_W     = $clog2(NUM_CELLS);

  logic          clk_1 = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          mode = 1'b0;
  logic [FW-1:0] pattern;
  logic          frame_valid;
  logic [7:0]    step_count;

  typedef struct packed {
    logic [FW-1:0] pat;
    logic          valid;
    logic [7:0]    cnt;
  } exp_t;

  exp_t expQ[$];
  int   validEdges[$];
  int   edgeNum = 0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0]   mDiv;
  logic [15:0]   mLfsr;
  logic [FW-1:0] mPattern;
  logic          mValid;
  logic [7:0]    mCount;

  pattern_generator_n #(
    .NUM_CELLS(NUM_CELLS), .PATTERN_W(PATTERN_W), .STEP_DIV(STEP_DIV), .SEED(SEED)
  ) dut (
    .clk_1(clk_1), .rst(rst), .enable(enable), .clear(clear), .mode(mode),
    .pattern(pattern), .frame_valid(frame_valid), .step_count(step_count)
  );

  always #5 clk_1 = ~clk_1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mDiv = 16'h0; mLfsr = SEED; mPattern = '0; mValid = 1'b0; mCount = 8'h0;
  endtask

  // Model of one rising edge given the inputs currently driven.
  task automatic modelEdge();
    logic [PATTERN_W-1:0] data;
    int idx;
    if (clear) begin
      modelReset();
    end else if (enable && mDiv == 16'(STEP_DIV - 1)) begin
      mDiv  = 16'h0;
      mLfsr = mLfsr[0] ? ((mLfsr >> 1) ^ 16'hB400) : (mLfsr >> 1);
      data  = mLfsr[PATTERN_W-1:0];
      if (mode) begin
        for (int k = NUM_CELLS - 1; k > 0; k--)
          mPattern[k*PATTERN_W +: PATTERN_W] = mPattern[(k-1)*PATTERN_W +: PATTERN_W];
        mPattern[PATTERN_W-1:0] = data;
      end else begin
        idx = int'(mCount) % NUM_CELLS;
        mPattern[idx*PATTERN_W +: PATTERN_W] = data;
      end
      mCount = mCount + 8'h1;
      mValid = 1'b1;
    end else begin
      if (enable) mDiv = mDiv + 16'h1;
      mValid = 1'b0;
    end
  endtask

  task automatic applyStimulus();
    exp_t e;
    modelEdge();
    e.pat = mPattern; e.valid = mValid; e.cnt = mCount;
    expQ.push_back(e);
    @(posedge clk_1);
    #1;
    edgeNum++;
    if (frame_valid) validEdges.push_back(edgeNum);
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = expQ.pop_front();
      checkOutput("pattern", 64'(pattern), 64'(e.pat));
      checkOutput("frame_valid", 64'(frame_valid), 64'(e.valid));
      checkOutput("step_count", 64'(step_count), 64'(e.cnt));
    end
  endtask

  task automatic doClear();
    clear = 1'b1; enable = 1'b0;
    applyStimulus();
    clear = 1'b0;
    edgeNum = 0;
    validEdges.delete();
  endtask

  function automatic int firstValid();
    return (validEdges.size() > 0) ? validEdges[0] : -1;
  endfunction

  initial begin
    modelReset();
    #2;
    checkOutput("reset_pattern", 64'(pattern), 64'd0);
    checkOutput("reset_valid", 64'(frame_valid), 64'd0);
    checkOutput("reset_count", 64'(step_count), 64'd0);
    @(negedge clk_1);
    rst = 1'b0;

    // Mode 0: steps at edges 4, 8, 12; cells 0,1,2 get 0,0,4.
    doClear();
    enable = 1'b1; mode = 1'b0;
    repeat (12) applyStimulus();
    checkOutput("m0_pulses", 64'(validEdges.size()), 64'd3);
    checkOutput("m0_edge1", 64'(firstValid()), 64'd4);
    if (validEdges.size() == 3) begin
      checkOutput("m0_edge2", 64'(validEdges[1]), 64'd8);
      checkOutput("m0_edge3", 64'(validEdges[2]), 64'd12);
    end
    checkOutput("m0_cell2", 64'(pattern[2*PATTERN_W +: PATTERN_W]), 64'd4);
    checkOutput("m0_frame", 64'(pattern), 64'h100);
    checkOutput("m0_count", 64'(step_count), 64'd3);

    // Mode 1: same stimulus, scrolled frame leaves 4 in cell 0 only.
    doClear();
    enable = 1'b1; mode = 1'b1;
    repeat (12) applyStimulus();
    checkOutput("m1_frame", 64'(pattern), 64'h4);
    checkOutput("m1_count", 64'(step_count), 64'd3);

    // Mode change between steps applies at the next step only.
    repeat (2) applyStimulus();
    mode = 1'b0;
    repeat (6) applyStimulus();

    // Pause: 5 disabled cycles at div_cnt=2 push the first step to edge 9.
    doClear();
    enable = 1'b1; mode = 1'b0;
    repeat (2) applyStimulus();
    enable = 1'b0;
    repeat (5) applyStimulus();
    enable = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("pause_edge", 64'(firstValid()), 64'd9);

    // Clear coincident with a step edge discards the step.
    doClear();
    enable = 1'b1; mode = 1'b0;
    repeat (6) applyStimulus();
    repeat (1) applyStimulus();
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
    checkOutput("clr_valid", 64'(frame_valid), 64'd0);
    checkOutput("clr_count", 64'(step_count), 64'd0);
    checkOutput("clr_pattern", 64'(pattern), 64'd0);
    repeat (12) applyStimulus();
    checkOutput("clr_reseed_frame", 64'(pattern), 64'h100);

    // Wrap: 256 steps return step_count to 0; the next step rewrites cell 0.
    doClear();
    enable = 1'b1; mode = 1'b0;
    repeat (256 * STEP_DIV) applyStimulus();
    checkOutput("wrap_count", 64'(step_count), 64'd0);
    checkOutput("wrap_pulses", 64'(validEdges.size()), 64'd256);
    repeat (STEP_DIV) applyStimulus();
    checkOutput("wrap_count_next", 64'(step_count), 64'd1);

    // Async reset mid-period clears outputs with no clock edge.
    mode = 1'b1;
    repeat (2 * STEP_DIV + 1) applyStimulus();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_pattern", 64'(pattern), 64'd0);
    checkOutput("async_valid", 64'(frame_valid), 64'd0);
    checkOutput("async_count", 64'(step_count), 64'd0);
    @(negedge clk_1);
    rst = 1'b0;
    edgeNum = 0;
    validEdges.delete();
    mode = 1'b0;
    repeat (12) applyStimulus();
    checkOutput("post_rst_edge", 64'(firstValid()), 64'd4);
    checkOutput("post_rst_frame", 64'(pattern), 64'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_generator_n.md
# pattern_generator_n

Parametrised next-generation pattern generator: produces a frame of `NUM_CELLS` cells, each `PATTERN_W` bits wide, from a 16-bit Galois LFSR. The frame advances once per programmable step period and feeds the display/scoring logic downstream. Two modes are supported:
- **Random-fill (mode 0):** one cell is rewritten per step.
- **Scroll (mode 1):** the whole frame shifts one cell per step.

Each frame update is flagged with a one-cycle valid pulse.

## Interface
- `NUM_CELLS`, 16: number of cells; power of two, 2..64.
- `PATTERN_W`, 3: bits per cell, 1..8.
- `STEP_DIV`, 4: clock cycles per step, 1..65535.
- `SEED`, 16'hACE1: LFSR load value; a value of 0 is replaced by 16'h0001.

Ports (clock and reset first):
- `clk_1`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  advance prescaler and steps while high.
- `clear`  in  1  synchronous frame clear and LFSR reseed.
- `mode`  in  1  0 = random-fill, 1 = scroll; sampled at step edges only.
- `pattern`  out  NUM_CELLS*PATTERN_W  registered frame; cell k is `pattern[k*PATTERN_W +: PATTERN_W]`.
- `frame_valid`  out  1  one-cycle pulse, high while a newly updated frame is first visible.
- `step_count`  out  8  number of steps taken, wrapping modulo 256.

## Operation
- **Prescaler:** `div_cnt`, 16-bit.
  - When `enable`=1: if `div_cnt`==STEP_DIV-1, it wraps to 0 and the internal `step` is asserted; otherwise it increments.
  - When `enable`=0: `div_cnt` holds its value (it is not cleared). `pattern` and `step_count` also hold, and `frame_valid`=0.
- **LFSR:** on each step, `lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0)`. The new value is `nv`; the cell data is `nv[PATTERN_W-1:0]`.
- **Mode 0 (random-fill):** on a step, cell index `step_count[log2(NUM_CELLS)-1:0]` (the pre-increment value) gets the new data. All other cells hold.
- **Mode 1 (scroll):** on a step, cell k <= cell k-1 for k=1..NUM_CELLS-1, and cell 0 gets the new data. The old top cell is discarded.
- **Counter and pulse on a step:** `step_count` increments, wrapping 255->0, and `frame_valid` is registered high for exactly one cycle.
- **`clear` (highest synchronous priority):** forces `pattern`=0, `lfsr`=SEED, `div_cnt`=0, `step_count`=0 and `frame_valid`=0.
  - This applies regardless of `enable`.
  - A step coincident with `clear` is discarded.
- **Reset (`rst` high, asynchronous):** `pattern`=0, `frame_valid`=0, `step_count`=0, `div_cnt`=0, `lfsr`=SEED.
  - Assertion mid-step aborts the step; no partial frame update occurs.
  - After `rst` deasserts, behaviour is identical to after `clear`.
- **`mode` changes:** a change between steps takes effect at the next step. The frame contents are not altered by the mode change itself.

## Timing
- **First step:** with `enable` continuously high starting from the first edge after `clear`/`rst` deassertion, the first step occurs on the STEP_DIV-th rising edge. Subsequent steps follow every STEP_DIV edges.
- **STEP_DIV=1:** a step occurs on every enabled edge, and `frame_valid` stays high continuously.
- **Pause and resume:** dropping `enable` for N cycles delays the next step by exactly N cycles. The remaining count is preserved.
- **Update latency:** `pattern`, `step_count` and `frame_valid` all update on the same edge that consumes the step, so there is zero cycles of skew between them.
- **`clear` release:** `clear` held high for any number of cycles holds everything at its cleared value. Counting resumes on the first edge with `clear`=0 and `enable`=1.

## Test plan
- **Reset values:** assert `rst` with defaults, then deassert → `pattern`=0, `frame_valid`=0, `step_count`=0.
- **Mode 0 sequence:** after `clear`, `enable`=1, `mode`=0 →
  - steps occur at edges 4, 8 and 12;
  - the LFSR produces 0xE270, 0x7138 and 0x389C;
  - cells 0, 1 and 2 are written with 0, 0 and 4;
  - `frame_valid` pulses once per step;
  - `step_count`=3.
- **Mode 1 sequence:** same stimulus with `mode`=1 → after step 3, cell0=4, cell1=0, cell2=0 (scrolled), all other cells 0.
- **Pause:** deassert `enable` for 5 cycles when `div_cnt`=2 → the next step occurs 5 cycles later than nominal, and `pattern` is unchanged during the pause.
- **Clear collision:** `clear` coincident with a step edge → no `frame_valid`; `pattern`=0; `step_count`=0; the next step yields cell data from `lfsr` 0xE270 again.
- **Wrap and async reset:** 256 steps wrap `step_count` to 0 with mode-0 index 0 rewritten; `rst` asserted asynchronously mid-period clears all outputs immediately, with no clock edge required.
